// File: rtl/sram_bist.sv
// rtl/sram_bist.sv - march-test BIST engine for a single-port SRAM
// Drives ADDR/WE/DIN of a registered-output, read-first SRAM and checks DOUT.
// March: W0 (w BG up), RW_UP (r BG, w ~BG up), RW_DN (r ~BG, w BG down), RD (r BG up).
// Ports:
//   CLK, RST (async active-high), START (one-cycle run request)
//   BUSY (run in progress), DONE (end-of-run pulse), PASS (valid from DONE)
//   ERR_CNT (saturating mismatch count), FAIL_ADDR/FAIL_EXP/FAIL_GOT (first mismatch)
//   ADDR, WE, DIN (registered SRAM drive), DOUT (SRAM read data)
// Option: define BIST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module sram_bist #(
  parameter int                ADDR_W = 10,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 1024,
  parameter logic [DATA_W-1:0] BG     = DATA_W'(8'h00)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [7:0]        ERR_CNT,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_EXP,
  output logic [DATA_W-1:0] FAIL_GOT,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WE,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_RW_UP, S_RW_DN, S_RD, S_DRAIN, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // state_q describes the bus cycle currently driven by addr_q/we_q/din_q.
  state_t              state_q, state_d;
  logic                phase_q, phase_d;   // RW elements: 0 = read cycle, 1 = write cycle
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0]   fail_got_q, fail_got_d;
  logic                pass_q, pass_d;

  logic                cmp_en;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [DATA_W-1:0]   cmp_exp;
  logic                mismatch;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    we_d        = we_q;
    din_d       = din_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;
    pass_d      = pass_q;
    cmp_en      = 1'b0;
    cmp_addr    = addr_q;
    cmp_exp     = BG;

    case (state_q)
      S_IDLE: begin
        we_d = 1'b0;
        if (START) begin
          state_d     = S_W0;
          addr_d      = '0;
          we_d        = 1'b1;
          din_d       = BG;
          phase_d     = 1'b0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_got_d  = '0;
          pass_d      = 1'b0;
        end
      end
      S_W0: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_RW_UP;
          addr_d  = '0;
          we_d    = 1'b0;
          phase_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_RW_UP: begin
        if (!phase_q) begin
          we_d    = 1'b1;
          din_d   = ~BG;
          phase_d = 1'b1;
        end else begin
          // DOUT now holds the read issued in the preceding read cycle.
          cmp_en  = 1'b1;
          cmp_exp = BG;
          we_d    = 1'b0;
          phase_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_RW_DN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_RW_DN: begin
        if (!phase_q) begin
          we_d    = 1'b1;
          din_d   = BG;
          phase_d = 1'b1;
        end else begin
          cmp_en  = 1'b1;
          cmp_exp = ~BG;
          we_d    = 1'b0;
          phase_d = 1'b0;
          if (addr_q == '0) begin
            state_d = S_RD;
          end else begin
            addr_d = addr_q - ADDR_W'(1);
          end
        end
      end
      S_RD: begin
        // Data for the previous address arrives now; address 0 has no predecessor.
        we_d     = 1'b0;
        cmp_en   = (addr_q != '0);
        cmp_addr = addr_q - ADDR_W'(1);
        cmp_exp  = BG;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        cmp_en  = 1'b1;
        cmp_exp = BG;
        we_d    = 1'b0;
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        addr_d  = '0;
        din_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
      end
    endcase

    mismatch = cmp_en && (DOUT != cmp_exp);
    if (mismatch) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (err_cnt_q == 8'd0) begin
        fail_addr_d = cmp_addr;
        fail_exp_d  = cmp_exp;
        fail_got_d  = DOUT;
      end
`ifdef BIST_STOP_ON_FAIL_EN
      state_d = S_FIN;
      we_d    = 1'b0;
      phase_d = 1'b0;
`endif
    end

    if (state_d == S_FIN) begin
      pass_d = (err_cnt_d == 8'd0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
      pass_q      <= pass_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign DONE      = (state_q == S_FIN);
  assign PASS      = pass_q;
  assign ERR_CNT   = err_cnt_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_EXP  = fail_exp_q;
  assign FAIL_GOT  = fail_got_q;
  assign ADDR      = addr_q;
  assign WE        = we_q;
  assign DIN       = din_q;

endmodule

// File: tb/tb_sram_bist.sv
// tb/tb_sram_bist.sv - self-checking bench for sram_bist with fault-injecting SRAM models
module tb_sram_bist;

  localparam int D = 1024;
  localparam logic [7:0] BGV = 8'h00;
`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit REF_STOP = 1'b1;
`else
  localparam bit REF_STOP = 1'b0;
`endif

  logic       clk, rst;
  logic       start, busy, done, pass, we;
  logic [7:0] err_cnt, fail_exp, fail_got, din, dout;
  logic [9:0] fail_addr, addr;

  logic       start4, busy4, done4, pass4, we4;
  logic [7:0] err_cnt4, fail_exp4, fail_got4, din4, dout4;
  logic [9:0] fail_addr4, addr4;

  int n_vec = 0;
  int n_err = 0;

  // Fault injection for the main SRAM: one bit stuck at fault_val at fault_addr.
  bit         fault_en = 1'b0;
  int         fault_addr = 0;
  logic [7:0] fault_mask = 8'h00;
  bit         fault_val = 1'b0;

  logic [7:0] mem  [0:1023];
  logic [7:0] mem4 [0:1023];
  logic [7:0] ref_mem [0:1023];

  int         m_cnt, m_busy;
  logic [9:0] m_addr;
  logic [7:0] m_exp, m_got;

  sram_bist #(.ADDR_W(10), .DATA_W(8), .DEPTH(D), .BG(BGV)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERR_CNT(err_cnt), .FAIL_ADDR(fail_addr), .FAIL_EXP(fail_exp), .FAIL_GOT(fail_got),
    .ADDR(addr), .WE(we), .DIN(din), .DOUT(dout)
  );

  sram_bist #(.ADDR_W(10), .DATA_W(8), .DEPTH(4), .BG(BGV)) dut4 (
    .CLK(clk), .RST(rst), .START(start4), .BUSY(busy4), .DONE(done4), .PASS(pass4),
    .ERR_CNT(err_cnt4), .FAIL_ADDR(fail_addr4), .FAIL_EXP(fail_exp4), .FAIL_GOT(fail_got4),
    .ADDR(addr4), .WE(we4), .DIN(din4), .DOUT(dout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] faulty(input int a, input logic [7:0] d);
    if (fault_en && a == fault_addr)
      return (d & ~fault_mask) | (fault_val ? fault_mask : 8'h00);
    return d;
  endfunction

  // Read-first registered SRAMs.
  always @(posedge clk) begin
    if (we) mem[addr] <= faulty(int'(addr), din);
    dout <= mem[addr];
  end

  always @(posedge clk) begin
    if (we4) mem4[addr4] <= din4;
    dout4 <= mem4[addr4];
  end

  // Reference: walk the march element by element; idx is the bus cycle
  // (counted from the first W0 write) at which that read's data is compared.
  task automatic ref_check(input int a, input logic [7:0] e, input int idx);
    if (REF_STOP && m_cnt != 0) return;
    if (ref_mem[a] !== e) begin
      if (m_cnt == 0) begin
        m_addr = 10'(a);
        m_exp  = e;
        m_got  = ref_mem[a];
        if (REF_STOP) m_busy = idx + 1;
      end
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic model_run();
    m_cnt = 0; m_addr = '0; m_exp = '0; m_got = '0; m_busy = 6 * D + 1;
    for (int a = 0; a < D; a++) ref_mem[a] = faulty(a, BGV);
    for (int a = 0; a < D; a++) begin
      ref_check(a, BGV, D + 2 * a + 1);
      ref_mem[a] = faulty(a, ~BGV);
    end
    for (int i = 0; i < D; i++) begin
      ref_check(D - 1 - i, ~BGV, 3 * D + 2 * i + 1);
      ref_mem[D - 1 - i] = faulty(D - 1 - i, BGV);
    end
    for (int a = 0; a < D; a++) ref_check(a, BGV, 5 * D + a + 1);
  endtask

  task automatic run_main(input string name, input int poke_at, input int e_busy,
                          input int e_cnt, input logic [9:0] e_addr,
                          input logic [7:0] e_exp, input logic [7:0] e_got);
    int nb;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || we !== 1'b1 || addr !== 10'd0 || pass !== 1'b0 || err_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL %s_start: busy=%b we=%b addr=%0d pass=%b err_cnt=%0d, want 1 1 0 0 0",
               name, busy, we, addr, pass, err_cnt);
    end
    nb = 0;
    while (busy === 1'b1 && nb < 20000) begin
      nb++;
      start = (nb == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (nb !== e_busy) begin
      n_err++;
      $display("FAIL %s_busy_len: got %0d want %0d", name, nb, e_busy);
    end
    n_vec++;
    if (done !== 1'b1 || pass !== (e_cnt == 0) || err_cnt !== 8'(e_cnt) || we !== 1'b0) begin
      n_err++;
      $display("FAIL %s_result: done=%b pass=%b err_cnt=%0d we=%b, want 1 %b %0d 0",
               name, done, pass, err_cnt, we, (e_cnt == 0), e_cnt);
    end
    n_vec++;
    if (fail_addr !== e_addr || fail_exp !== e_exp || fail_got !== e_got) begin
      n_err++;
      $display("FAIL %s_capture: addr=%0d exp=%h got=%h, want %0d %h %h",
               name, fail_addr, fail_exp, fail_got, e_addr, e_exp, e_got);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0 || pass !== (e_cnt == 0)) begin
      n_err++;
      $display("FAIL %s_after: done=%b busy=%b we=%b pass=%b, want 0 0 0 %b",
               name, done, busy, we, pass, (e_cnt == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    #1;
    n_vec++;
    if (busy !== 0 || done !== 0 || pass !== 0 || err_cnt !== 0 || we !== 0 || addr !== 0 ||
        din !== 0 || fail_addr !== 0 || fail_exp !== 0 || fail_got !== 0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b pass=%b err=%0d we=%b addr=%0d din=%h fa=%0d fe=%h fg=%h, want all 0",
               busy, done, pass, err_cnt, we, addr, din, fail_addr, fail_exp, fail_got);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_run();
    fault_en = 1'b0;
    model_run();
    run_main("clean", 0, m_busy, m_cnt, m_addr, m_exp, m_got);
    n_vec++;
    if (m_busy != 6 * D + 1 || m_cnt != 0) begin
      n_err++;
      $display("FAIL clean_model: busy %0d cnt %0d, want %0d 0", m_busy, m_cnt, 6 * D + 1);
    end
  endtask

  task automatic test_fault(input string name, input int fa, input int fb, input bit fv);
    fault_en = 1'b1; fault_addr = fa; fault_mask = 8'(1 << fb); fault_val = fv;
    model_run();
    run_main(name, 0, m_busy, m_cnt, m_addr, m_exp, m_got);
    fault_en = 1'b0;
  endtask

  task automatic test_addr5_stuck1();
    test_fault("addr5_sa1", 5, 0, 1'b1);
    n_vec++;
    if (err_cnt !== (REF_STOP ? 8'd1 : 8'd2) || fail_addr !== 10'd5 ||
        fail_exp !== 8'h00 || fail_got !== 8'h01) begin
      n_err++;
      $display("FAIL addr5_plan: err=%0d fa=%0d fe=%h fg=%h, want %0d 5 00 01",
               err_cnt, fail_addr, fail_exp, fail_got, REF_STOP ? 1 : 2);
    end
  endtask

  task automatic test_random_faults();
    for (int k = 0; k < 2; k++)
      test_fault($sformatf("rand_fault%0d", k), int'($urandom_range(0, D - 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_start_ignored();
    fault_en = 1'b0;
    run_main("start_mid", int'($urandom_range(D + 1, 3 * D - 1)), 6 * D + 1, 0, '0, '0, '0);
  endtask

  task automatic test_depth4_trace();
    logic [9:0] ea[$];
    logic       ew[$];
    logic [7:0] ed[$];
    for (int a = 0; a < 4; a++) begin ea.push_back(10'(a)); ew.push_back(1); ed.push_back(BGV); end
    for (int a = 0; a < 4; a++) begin
      ea.push_back(10'(a)); ew.push_back(0); ed.push_back(8'h00);
      ea.push_back(10'(a)); ew.push_back(1); ed.push_back(~BGV);
    end
    for (int a = 3; a >= 0; a--) begin
      ea.push_back(10'(a)); ew.push_back(0); ed.push_back(8'h00);
      ea.push_back(10'(a)); ew.push_back(1); ed.push_back(BGV);
    end
    for (int a = 0; a < 4; a++) begin ea.push_back(10'(a)); ew.push_back(0); ed.push_back(8'h00); end
    ea.push_back(10'd3); ew.push_back(0); ed.push_back(8'h00);
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    for (int i = 0; i < ea.size(); i++) begin
      n_vec++;
      if (busy4 !== 1'b1 || we4 !== ew[i] || (ew[i] && din4 !== ed[i]) ||
          (i < 24 && addr4 !== ea[i]) || addr4 === 10'd1023) begin
        n_err++;
        $display("FAIL d4_trace[%0d]: busy=%b addr=%0d we=%b din=%h, want 1 %0d %b %h",
                 i, busy4, addr4, we4, din4, ea[i], ew[i], ed[i]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (busy4 !== 1'b0 || done4 !== 1'b1 || pass4 !== 1'b1 || err_cnt4 !== 8'd0 || we4 !== 1'b0) begin
      n_err++;
      $display("FAIL d4_done: busy=%b done=%b pass=%b err=%0d we=%b, want 0 1 1 0 0",
               busy4, done4, pass4, err_cnt4, we4);
    end
  endtask

  task automatic test_reset_mid_run();
    int wait_cyc;
    fault_en = 1'b0;
    wait_cyc = int'($urandom_range(3 * D + 2, 5 * D - 2));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (wait_cyc - 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 0 || we !== 0 || done !== 0 || addr !== 0 || err_cnt !== 0 || pass !== 0) begin
      n_err++;
      $display("FAIL rst_mid: busy=%b we=%b done=%b addr=%0d err=%0d pass=%b, want all 0",
               busy, we, done, addr, err_cnt, pass);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_main("after_rst", 0, 6 * D + 1, 0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_addr5_stuck1();
    test_random_faults();
    test_start_ignored();
    test_depth4_trace();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bist.md
# sram_bist

Built-in self-test engine that drives the single-port `SRAM` block's `ADDR/WE/DIN` port as initiator and checks its `DOUT`. On `START` it runs a fixed march sequence over every address, compares read data against expected values and reports pass/fail with first-failure capture. It sits beside the SRAM and muxes onto its port in test mode; the mux lives outside this block.

## Interface
- `ADDR_W`, 10, SRAM address width
- `DATA_W`, 8, SRAM data width
- `DEPTH`, 1024, number of words tested, addresses 0..DEPTH-1, 2 ≤ DEPTH ≤ 2^ADDR_W
- `BG`, 8'h00, background pattern; its complement `~BG` is the alternate pattern
- `CLK` in 1: single clock, SRAM samples on rising edge
- `RST` in 1: asynchronous, active-high reset
- `START` in 1: one-cycle request to begin a run
- `BUSY` out 1: run in progress
- `DONE` out 1: one-cycle pulse at run end
- `PASS` out 1: valid from `DONE` until next accepted `START`
- `ERR_CNT` out 8: mismatches in this run, saturates at 255
- `FAIL_ADDR` out ADDR_W: address of first mismatch
- `FAIL_EXP` out DATA_W: expected data at first mismatch
- `FAIL_GOT` out DATA_W: `DOUT` at first mismatch
- `ADDR` out ADDR_W, `WE` out 1, `DIN` out DATA_W: drive SRAM
- `DOUT` in DATA_W: SRAM read data

## Operation
- SRAM contract: `DOUT` registered, updated every edge with `mem[ADDR]` read-first; one-cycle read latency.
- States: IDLE → W0 → RW_UP → RW_DN → RD → DRAIN → FIN → IDLE.
- IDLE: `WE=0`; `START` accepted only here; acceptance clears `ERR_CNT`, `FAIL_*`, `PASS`.
- W0: ascending 0..DEPTH-1, one write per cycle, `DIN=BG`.
- RW_UP: ascending; per address two cycles: read (`WE=0`), then write `~BG` to same address; `DOUT` sampled at end of write cycle, expected `BG`.
- RW_DN: descending DEPTH-1..0, same two-cycle pair, expect `~BG`, write `BG`. Down counter stops at 0, never wraps.
- RD: ascending, read every cycle, expect `BG`; compare pipelined one cycle behind address.
- DRAIN: compare for last RD address; `WE=0`.
- FIN: `DONE=1`, `BUSY=0`, `PASS=(ERR_CNT==0)`; next cycle IDLE.
- Mismatch: `ERR_CNT` increments (saturating); `FAIL_*` loaded only when `ERR_CNT` was 0.
- `ADDR/WE/DIN` registered; `WE` never high outside W0, RW_UP, RW_DN.

## Timing
- Reset values: `ADDR=0, WE=0, DIN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_ADDR=0, FAIL_EXP=0, FAIL_GOT=0`, state IDLE.
- `START` sampled at edge k → `BUSY=1` and first W0 write on bus from edge k.
- BUSY cycles: W0 DEPTH + RW_UP 2·DEPTH + RW_DN 2·DEPTH + RD DEPTH + DRAIN 1 = 6·DEPTH+1; `DONE` the following cycle.
- `START` while BUSY or FIN: ignored, no restart.
- `RST` mid-run: outputs to reset values immediately (async), run aborted, SRAM contents undefined; next `START` runs fully.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined: on first mismatch go straight to FIN the next cycle (`WE=0`), `PASS=0`, `ERR_CNT=1`.
- Undefined: run always completes all states; `ERR_CNT` counts every mismatch.

## Test plan
- Fault-free SRAM model, DEPTH=1024, pulse `START` → `BUSY` high 6145 cycles, `DONE` pulse, `PASS=1`, `ERR_CNT=0`.
- Bit0 stuck-at-1 at address 5, default macro → `PASS=0`, `ERR_CNT=2`, `FAIL_ADDR=5`, `FAIL_EXP=8'h00`, `FAIL_GOT=8'h01`.
- Same fault with `BIST_STOP_ON_FAIL_EN` → `DONE` two cycles after RW_UP read of address 5, `ERR_CNT=1`, `FAIL_ADDR=5`.
- DEPTH=4 → bus trace W0 writes 0,1,2,3 with 8'h00; RW_UP 0,0,1,1,2,2,3,3 (WE 0/1); RW_DN 3,3,2,2,1,1,0,0; RD 0,1,2,3; `ADDR` never 1023.
- `START` pulsed mid RW_UP → ignored, total BUSY length unchanged.
- `RST` asserted mid RW_DN → `WE=0`, `BUSY=0` same cycle; new `START` → full clean run, `PASS=1`.
